// File: rtl/reg_cmd_ctrl_pkg.sv
// Shared definitions for the UART command front end: command bytes, FSM states, defaults.
package reg_cmd_ctrl_pkg;

  localparam logic [7:0] CMD_WR = 8'hAA;
  localparam logic [7:0] CMD_RD = 8'hBB;

  localparam int unsigned TIMEOUT_DEFAULT = 1024;

  typedef enum logic [2:0] {
    StIdle,
    StWrAddr,
    StWrData,
    StWrExec,
    StRdAddr,
    StRdExec,
    StRdWait,
    StTxSend
  } state_e;

  // States that wait on the next byte of a frame and are therefore guarded by the frame timer.
  function automatic logic is_timed(input state_e s);
    return (s == StWrAddr) || (s == StWrData) || (s == StRdAddr);
  endfunction

endpackage

// File: rtl/reg_cmd_ctrl_if.sv
// Bus bundle between the command controller and its UART / register-file neighbours.
interface reg_cmd_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ADDR  = 4
) ();

  logic [WIDTH-1:0] RX_P_DATA;
  logic             RX_D_VLD;
  logic             RF_WrEn;
  logic             RF_RdEn;
  logic [ADDR-1:0]  RF_Address;
  logic [WIDTH-1:0] RF_WrData;
  logic [WIDTH-1:0] RF_RdData;
  logic             RF_RdData_VLD;
  logic [WIDTH-1:0] TX_P_DATA;
  logic             TX_D_VLD;
  logic             TX_BUSY;
  logic             CMD_ERR;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RF_RdData, RF_RdData_VLD, TX_BUSY,
    output RF_WrEn, RF_RdEn, RF_Address, RF_WrData, TX_P_DATA, TX_D_VLD, CMD_ERR
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RF_RdData, RF_RdData_VLD, TX_BUSY,
    input  RF_WrEn, RF_RdEn, RF_Address, RF_WrData, TX_P_DATA, TX_D_VLD, CMD_ERR
  );

endinterface

// File: rtl/reg_cmd_ctrl_frame_timer.sv
// Frame timer: loadable down-counter with clear and enable; flags expiry when enabled at zero.
module reg_cmd_ctrl_frame_timer #(
  parameter int unsigned CW = 10
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_en,
  output logic          o_expire
);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expire = i_en && (r_count == '0);

endmodule

// File: rtl/reg_cmd_ctrl.sv
// Command front end: parses write/read frames from the UART receiver, drives register-file
// strobes and returns read data to the UART transmitter.
module reg_cmd_ctrl
  import reg_cmd_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ADDR    = 4,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic           CLK,
  input  logic           RST,
  reg_cmd_ctrl_if.master bus
);

  localparam int unsigned     TmrW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Loaded on byte acceptance so the counter hits zero TIMEOUT-1 cycles later.
  localparam logic [TmrW-1:0] TmrLoad = TmrW'(TIMEOUT - 2);

  state_e           r_state, w_state_nxt;
  logic             r_wr_en, w_wr_en_nxt;
  logic             r_rd_en, w_rd_en_nxt;
  logic [ADDR-1:0]  r_addr, w_addr_nxt;
  logic [WIDTH-1:0] r_wr_data, w_wr_data_nxt;
  logic [WIDTH-1:0] r_rd_data, w_rd_data_nxt;
  logic [WIDTH-1:0] r_tx_data, w_tx_data_nxt;
  logic             r_tx_vld, w_tx_vld_nxt;
  logic             r_err, w_err_nxt;

  logic w_addr_ok;
  logic w_tmr_load;
  logic w_tmr_clear;
  logic w_tmr_en;
  logic w_tmr_expire;

  assign w_addr_ok = (32'(bus.RX_P_DATA) < DEPTH);

  // A byte arriving on the expiry cycle suppresses the timeout because it disables the timer.
  always_comb begin
    w_tmr_en    = is_timed(r_state) && !bus.RX_D_VLD;
    w_tmr_load  = bus.RX_D_VLD && is_timed(w_state_nxt);
    w_tmr_clear = !is_timed(w_state_nxt);
  end

  reg_cmd_ctrl_frame_timer #(
    .CW (TmrW)
  ) u_frame_timer (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_clear    (w_tmr_clear),
    .i_load     (w_tmr_load),
    .i_load_val (TmrLoad),
    .i_en       (w_tmr_en),
    .o_expire   (w_tmr_expire)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_wr_en_nxt   = 1'b0;
    w_rd_en_nxt   = 1'b0;
    w_addr_nxt    = r_addr;
    w_wr_data_nxt = r_wr_data;
    w_rd_data_nxt = r_rd_data;
    w_tx_data_nxt = r_tx_data;
    w_tx_vld_nxt  = 1'b0;
    w_err_nxt     = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (bus.RX_D_VLD) begin
          if (bus.RX_P_DATA == WIDTH'(CMD_WR)) begin
            w_state_nxt = StWrAddr;
          end else if (bus.RX_P_DATA == WIDTH'(CMD_RD)) begin
            w_state_nxt = StRdAddr;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end

      StWrAddr, StRdAddr: begin
        if (bus.RX_D_VLD) begin
          if (w_addr_ok) begin
            w_addr_nxt  = bus.RX_P_DATA[ADDR-1:0];
            w_state_nxt = (r_state == StWrAddr) ? StWrData : StRdExec;
            w_rd_en_nxt = (r_state == StRdAddr);
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = StIdle;
          end
        end else if (w_tmr_expire) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = StIdle;
        end
      end

      StWrData: begin
        if (bus.RX_D_VLD) begin
          w_wr_data_nxt = bus.RX_P_DATA;
          w_wr_en_nxt   = 1'b1;
          w_state_nxt   = StWrExec;
        end else if (w_tmr_expire) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = StIdle;
        end
      end

      StWrExec: w_state_nxt = StIdle;

      StRdExec: w_state_nxt = StRdWait;

      StRdWait: begin
        if (bus.RF_RdData_VLD) begin
          w_rd_data_nxt = bus.RF_RdData;
          if (!bus.TX_BUSY) begin
            w_tx_data_nxt = bus.RF_RdData;
            w_tx_vld_nxt  = 1'b1;
            w_state_nxt   = StIdle;
          end else begin
            w_state_nxt = StTxSend;
          end
        end
      end

      StTxSend: begin
        if (!bus.TX_BUSY) begin
          w_tx_data_nxt = r_rd_data;
          w_tx_vld_nxt  = 1'b1;
          w_state_nxt   = StIdle;
        end
      end

      default: w_state_nxt = StIdle;
    endcase

    // Bytes arriving while an operation is in flight are dropped and reported.
    if (bus.RX_D_VLD && ((r_state == StWrExec) || (r_state == StRdExec) ||
                         (r_state == StRdWait) || (r_state == StTxSend))) begin
      w_err_nxt = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= StIdle;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_rd_data <= '0;
      r_tx_data <= '0;
      r_tx_vld  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_rd_en   <= w_rd_en_nxt;
      r_addr    <= w_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_rd_data <= w_rd_data_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_tx_vld  <= w_tx_vld_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign bus.RF_WrEn    = r_wr_en;
  assign bus.RF_RdEn    = r_rd_en;
  assign bus.RF_Address = r_addr;
  assign bus.RF_WrData  = r_wr_data;
  assign bus.TX_P_DATA  = r_tx_data;
  assign bus.TX_D_VLD   = r_tx_vld;
  assign bus.CMD_ERR    = r_err;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Scoreboard bench for reg_cmd_ctrl: expected strobes/bytes/errors are queued with their cycle.
module tb_reg_cmd_ctrl;

  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic [7:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  exp_t q_wr[$];
  exp_t q_rd[$];
  exp_t q_tx[$];
  int   q_err[$];

  logic [7:0] mem [16];

  reg_cmd_ctrl_if #(.WIDTH(8), .ADDR(4)) bus ();

  reg_cmd_ctrl #(
    .WIDTH   (8),
    .DEPTH   (16),
    .ADDR    (4),
    .TIMEOUT (16)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Register-file model: one-cycle read latency.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.RF_RdData_VLD <= 1'b0;
      bus.RF_RdData     <= 8'h00;
      for (int i = 0; i < 16; i++) mem[i] <= 8'h40 + 8'(i);
      mem[2] <= 8'h7E;
    end else begin
      bus.RF_RdData_VLD <= bus.RF_RdEn;
      if (bus.RF_RdEn) bus.RF_RdData <= mem[bus.RF_Address];
      if (bus.RF_WrEn) mem[bus.RF_Address] <= bus.RF_WrData;
    end
  end

  always @(negedge clk) begin : mon
    logic ew, er, et, ee;
    exp_t e;
    if (!rst) begin
      ew = (q_wr.size() != 0) && (q_wr[0].cyc == cyc);
      er = (q_rd.size() != 0) && (q_rd[0].cyc == cyc);
      et = (q_tx.size() != 0) && (q_tx[0].cyc == cyc);
      ee = (q_err.size() != 0) && (q_err[0] == cyc);
      check_eq("wr_en", 32'(bus.RF_WrEn), 32'(ew));
      check_eq("rd_en", 32'(bus.RF_RdEn), 32'(er));
      check_eq("tx_vld", 32'(bus.TX_D_VLD), 32'(et));
      check_eq("cmd_err", 32'(bus.CMD_ERR), 32'(ee));
      check_eq("strobe_excl", 32'(bus.RF_WrEn & bus.RF_RdEn), 32'd0);
      if (ew) begin
        e = q_wr.pop_front();
        check_eq("wr_addr", 32'(bus.RF_Address), 32'(e.a));
        check_eq("wr_data", 32'(bus.RF_WrData), 32'(e.d));
      end
      if (er) begin
        e = q_rd.pop_front();
        check_eq("rd_addr", 32'(bus.RF_Address), 32'(e.a));
      end
      if (et) begin
        e = q_tx.pop_front();
        check_eq("tx_data", 32'(bus.TX_P_DATA), 32'(e.d));
      end
      if (ee) void'(q_err.pop_front());
    end
  end

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge; pulses RX_D_VLD for exactly one cycle.
  task automatic send(input logic [7:0] b, output int n);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    n = cyc;
    @(posedge clk);
    #1;
    bus.RX_D_VLD = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    int n;
    send(8'hAA, n);
    send(a, n);
    send(d, n);
    q_wr.push_back('{n + 1, a, d});
    idle(4);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] d);
    int n;
    send(8'hBB, n);
    send(a, n);
    q_rd.push_back('{n + 1, a, 8'h00});
    q_tx.push_back('{n + 3, 8'h00, d});
    idle(6);
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.RF_WrEn, bus.RF_RdEn, bus.RF_Address, bus.RF_WrData,
                bus.TX_P_DATA, bus.TX_D_VLD, bus.CMD_ERR});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n0;
    bus.RX_P_DATA = 8'h00;
    bus.RX_D_VLD  = 1'b0;
    bus.TX_BUSY   = 1'b0;
    #12;
    check_eq("reset_outs", outs(), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    do_write(8'h05, 8'h3C);
    do_read(8'h02, 8'h7E);

    // Backpressure with an overflow byte dropped while waiting to transmit.
    bus.TX_BUSY = 1'b1;
    send(8'hBB, n);
    send(8'h02, n);
    q_rd.push_back('{n + 1, 8'h02, 8'h00});
    idle(5);
    send(8'h99, n);
    q_err.push_back(n + 1);
    idle(13);
    bus.TX_BUSY = 1'b0;
    q_tx.push_back('{cyc + 1, 8'h00, 8'h7E});
    idle(6);

    send(8'h55, n);
    q_err.push_back(n + 1);
    idle(3);
    send(8'hAA, n);
    send(8'h10, n);
    q_err.push_back(n + 1);
    idle(3);
    do_write(8'h07, 8'hC3);
    do_read(8'h07, 8'hC3);

    // Silent read frame times out TIMEOUT-1 cycles after the command byte.
    send(8'hBB, n0);
    q_err.push_back(n0 + 16);
    idle(22);

    // Address byte landing exactly on the expiry cycle is still accepted.
    send(8'hBB, n0);
    idle(14);
    send(8'h02, n);
    q_rd.push_back('{n + 1, 8'h02, 8'h00});
    q_tx.push_back('{n + 3, 8'h00, 8'h7E});
    idle(6);

    // Asynchronous reset in the middle of a write frame.
    send(8'hAA, n);
    send(8'h03, n);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_outs", outs(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    do_write(8'h03, 8'h11);
    do_read(8'h03, 8'h11);

    idle(10);
    check_eq("pending_left", 32'(q_wr.size() + q_rd.size() + q_tx.size() + q_err.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_cmd_ctrl.md
Name: reg_cmd_ctrl

Overview:
- Command front end directly upstream of the register file.
- Consumes bytes from the UART receiver, decodes write and read frames, and drives the register-file access strobes.
- Forwards read data to the UART transmitter through a valid/busy handshake.
- Flags malformed, out-of-range and stalled frames.

Parameters:
- WIDTH, 8, data/byte width.
- DEPTH, 16, register-file entries; addresses >= DEPTH are illegal.
- ADDR, 4, register-file address width.
- TIMEOUT, 1024, max cycles allowed between bytes inside a frame.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-high reset.
- RX_P_DATA  in  WIDTH  received byte.
- RX_D_VLD  in  1  one-cycle pulse; RX_P_DATA valid.
- RF_WrEn  out  1  register-file write strobe.
- RF_RdEn  out  1  register-file read strobe.
- RF_Address  out  ADDR  register-file address.
- RF_WrData  out  WIDTH  register-file write data.
- RF_RdData  in  WIDTH  register-file read data.
- RF_RdData_VLD  in  1  register-file read data valid.
- TX_P_DATA  out  WIDTH  byte to transmit.
- TX_D_VLD  out  1  one-cycle pulse; TX_P_DATA valid.
- TX_BUSY  in  1  transmitter busy; no new byte accepted while high.
- CMD_ERR  out  1  one-cycle error pulse.

Behaviour:
- Reset is asynchronous and active-high: RST=1 immediately forces state IDLE and all outputs to 0, clears the timeout counter and the captured read data. Reset mid-frame discards the frame with no RF access.
- All outputs are registered. RF_WrEn and RF_RdEn are never high together, because the register file ignores simultaneous strobes.
- Frame formats:
  - 0xAA, addr, data = write.
  - 0xBB, addr = read.
- States: IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_SEND.
- IDLE, on RX_D_VLD:
  - 0xAA -> WR_ADDR.
  - 0xBB -> RD_ADDR.
  - any other byte -> CMD_ERR pulse next cycle, stay IDLE.
- WR_ADDR / RD_ADDR, on RX_D_VLD:
  - Byte >= DEPTH -> CMD_ERR, IDLE.
  - Otherwise latch byte[ADDR-1:0] into RF_Address, then go to WR_DATA or RD_EXEC respectively.
- WR_DATA, on RX_D_VLD: latch RF_WrData -> WR_EXEC. RF_WrEn is high exactly one cycle, in the cycle after the data byte pulse, then IDLE.
- RD_EXEC: RF_RdEn high exactly one cycle -> RD_WAIT.
- RD_WAIT: on RF_RdData_VLD, capture RF_RdData -> TX_SEND.
- TX_SEND: when TX_BUSY=0, drive TX_P_DATA and pulse TX_D_VLD one cycle -> IDLE. Otherwise hold until TX_BUSY=0, with no timeout.
- Latency:
  - Write: data byte pulse at cycle n -> RF_WrEn at n+1.
  - Read: addr pulse at n -> RF_RdEn at n+1 -> VLD at n+2 -> TX_D_VLD at n+3 if TX_BUSY=0.
- Timeout:
  - Applies in WR_ADDR, WR_DATA and RD_ADDR. A counter restarts on each accepted byte.
  - Reaching TIMEOUT-1 cycles with no RX_D_VLD -> CMD_ERR, IDLE, no RF access.
  - A byte arriving in the same cycle as expiry is accepted, and the timeout is not taken.
- Overflow: RX_D_VLD in WR_EXEC, RD_EXEC, RD_WAIT or TX_SEND drops the byte and pulses CMD_ERR; the current operation completes normally.
- RF_Address and RF_WrData hold their last values between frames.

Decomposition:
- Shared package holds:
  - command constants CMD_WR=8'hAA and CMD_RD=8'hBB;
  - the state enumeration (3-bit encoding);
  - the default TIMEOUT value.
- One natural sub-module: frame_timer, a loadable down-counter with clear, enable and expire outputs, reused later by other frame parsers.

Test Plan:
- Write: RX 0xAA, 0x05, 0x3C -> one cycle of RF_WrEn=1 with RF_Address=5 and RF_WrData=0x3C, one cycle after the 0x3C pulse; CMD_ERR stays 0.
- Read: RF model returns 0x7E; RX 0xBB, 0x02 with TX_BUSY=0 -> RF_RdEn one cycle at n+1, then TX_P_DATA=0x7E with TX_D_VLD at n+3.
- Backpressure: same read with TX_BUSY=1 for 20 cycles -> TX_D_VLD is asserted the cycle after TX_BUSY falls, data 0x7E, exactly one pulse.
- Errors:
  - RX 0x55 -> CMD_ERR pulse, state stays IDLE.
  - RX 0xAA, 0x10 (>= DEPTH) -> CMD_ERR, no RF_WrEn.
  - Next valid frame executes normally.
- Timeout: TIMEOUT=16; RX 0xBB then silence -> CMD_ERR once, no RF_RdEn. A byte sent on the expiry cycle is accepted.
- Reset mid-frame: RX 0xAA, 0x03, then RST=1 asynchronously for 2 cycles -> all outputs 0 immediately, no RF_WrEn. A following 0xAA, 0x03, 0x11 writes 0x11 to address 3.
